// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment/legality check applied when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // 1 when the size code is illegal or the byte offset breaks natural alignment
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response channel plus the word-addressed data-memory port.
// slave = the load/store unit, master = the core/memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit_lane.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges sub-word store data into the word read back for read-modify-write.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        unsigned_ld,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = unsigned_ld ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_data = unsigned_ld ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = rdata;
    endcase
  end

  // Untouched lanes pass through bit-exact from the read word
  always_comb begin
    merged = rdata;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte/half/word requests from execute, drives a
// word-addressed memory (comb read, sync write) and returns a one-cycle response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready; latch request, route to RD / WR / RESP (on error)
// RD      | memory read of latched word; load -> RESP, sub-word store -> WR
// WR      | single-cycle write strobe with merged or full word
// RESP    | resp_valid pulse with rdata/err, then back to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input logic               clk,
  input logic               reset_n,
  load_store_unit_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] WORD_LIMIT = IDX_W'(MEM_WORDS);

  lsu_state_e       state;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  size_e            size_q;
  logic             uns_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data;
  logic [31:0]      merged;
  logic             accept;
  logic             req_err;

  lsu_lane u_lane (
    .rdata       (bus.mem_rdata),
    .wdata       (wdata_q),
    .off         (off_q),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = access_err(bus.req_size, bus.req_addr[1:0])
                         || (bus.req_addr[ADDR_W-1:2] >= WORD_LIMIT);
  assign bus.mem_addr  = 32'(idx_q);
  // Gated by reset_n so a reset asserted during WR never reaches memory
  assign bus.mem_we    = (state == ST_WR) && reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      idx_q          <= '0;
      off_q          <= 2'b00;
      size_q         <= SZ_BYTE;
      uns_q          <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= 32'b0;
      bus.mem_wdata  <= 32'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= bus.req_addr[ADDR_W-1:2];
            off_q   <= bus.req_addr[1:0];
            size_q  <= size_e'(bus.req_size);
            uns_q   <= bus.req_unsigned;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            if (req_err) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'b0;
            end else if (bus.req_we && bus.req_size == SZ_WORD) begin
              state         <= ST_WR;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (we_q) begin
            bus.mem_wdata <= merged;
            state         <= ST_WR;
          end else begin
            bus.resp_rdata <= load_data;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_WR: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= 32'b0;
          bus.resp_err   <= 1'b0;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= 32'b0;
          bus.resp_err   <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked
// against an arithmetic model of memory contents and lane behaviour.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 32;
  localparam int ADDR_W    = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Harness memory: combinational read, synchronous write
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        mem_loaded = 1'b0;
  int          we_count = 0;
  int          resp_count = 0;
  int          we_in_reset = 0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  assign bus.mem_rdata = (bus.mem_addr < 32'(MEM_WORDS)) ? mem[bus.mem_addr[4:0]] : 32'hDEAD0000;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_we && bus.mem_addr < 32'(MEM_WORDS)) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
    if (bus.mem_we) begin
      we_count++;
      last_we_addr = bus.mem_addr;
      last_we_data = bus.mem_wdata;
      if (!reset_n) we_in_reset++;
    end
    if (bus.resp_valid) resp_count++;
  end

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int lat,
                                output int writes, output logic [31:0] new_word);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] word, mask, lane;
    idx = addr / 4;
    sh  = (addr % 4) * 8;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (idx >= MEM_WORDS);
    rdata = 32'b0; writes = 0; new_word = 32'b0; lat = 1;
    if (err) return;
    word = ref_mem[idx];
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    if (!we) begin
      lane = (word >> sh) & mask;
      if (!uns && size != 2'd2 && (lane & ((mask >> 1) + 1)) != 0) lane = lane | ~mask;
      rdata = lane;
      lat   = 2;
    end else begin
      new_word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      writes   = 1;
      lat      = (size == 2'd2) ? 2 : 3;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string name, output logic [31:0] got);
    logic [31:0] exp_rdata, exp_word;
    logic        exp_err;
    int          exp_lat, exp_w, w0, r0, lat, waits;
    model(we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_w, exp_word);
    got = 32'hx;
    @(negedge clk);
    w0 = we_count; r0 = resp_count;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    waits = 0;
    while (!bus.req_ready && waits < 10) begin @(negedge clk); waits++; end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL %s accept: req_ready=0 after 10 cycles, want 1", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (bus.resp_valid) break;
    end
    checks++;
    if (!bus.resp_valid) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within 10 cycles", name);
      return;
    end
    got = bus.resp_rdata;
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.resp_rdata !== exp_rdata || bus.resp_err !== exp_err) begin
      errors++;
      $display("FAIL %s resp: rdata=%h err=%b want rdata=%h err=%b", name,
               bus.resp_rdata, bus.resp_err, exp_rdata, exp_err);
    end
    checks++;
    if (we_count - w0 != exp_w) begin
      errors++; $display("FAIL %s writes: got %0d want %0d", name, we_count - w0, exp_w);
    end else if (exp_w == 1) begin
      checks++;
      if (last_we_addr !== addr / 4 || last_we_data !== exp_word) begin
        errors++;
        $display("FAIL %s wdata: addr=%h data=%h want addr=%h data=%h", name,
                 last_we_addr, last_we_data, addr / 4, exp_word);
      end
      ref_mem[addr / 4] = exp_word;
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || resp_count - r0 != 1) begin
      errors++;
      $display("FAIL %s pulse: resp_valid=%b pulses=%0d want 0 and 1", name,
               bus.resp_valid, resp_count - r0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        bus.resp_rdata !== 32'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'b0 ||
        bus.mem_wdata !== 32'b0) begin
      errors++;
      $display("FAIL reset: ready=%b rv=%b err=%b rdata=%h we=%b maddr=%h mwdata=%h want 1 0 0 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_load_word();
    logic [31:0] got;
    do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, "lw_0c", got);
    checks++;
    if (got !== 32'h3) begin errors++; $display("FAIL lw_0c value: got %h want 00000003", got); end
  endtask

  task automatic test_store_byte();
    logic [31:0] got;
    do_req(1'b1, 2'd0, 1'b0, 32'h0D, 32'hAB, "sb_0d", got);
    checks++;
    if (last_we_data !== 32'h0000AB03) begin
      errors++; $display("FAIL sb_0d merge: got %h want 0000ab03", last_we_data);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, "lb_0d", got);
    checks++;
    if (got !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_0d value: got %h want ffffffab", got); end
    do_req(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, "lbu_0d", got);
  endtask

  task automatic test_store_half();
    logic [31:0] got;
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h8001, "sh_12", got);
    checks++;
    if (last_we_data !== 32'h80010004) begin
      errors++; $display("FAIL sh_12 merge: got %h want 80010004", last_we_data);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lh_12", got);
    checks++;
    if (got !== 32'hFFFF8001) begin errors++; $display("FAIL lh_12 value: got %h want ffff8001", got); end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lhu_12", got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, "lw_misalign", got);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, "lw_range", got);
    do_req(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, "size_11", got);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234, "sh_misalign", got);
    do_req(1'b1, 2'd0, 1'b0, 32'h7F, 32'h55, "sb_last", got);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] got;
    int w0, r0;
    @(negedge clk);
    w0 = we_count; r0 = resp_count;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_wr mem_we: got %b want 0", bus.mem_we); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (we_count != w0 || resp_count != r0 || we_in_reset != 0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr abort: writes=%0d pulses=%0d ready=%b want 0 0 1",
               we_count - w0, resp_count - r0, bus.req_ready);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "lw_14", got);
    checks++;
    if (got !== 32'h5) begin errors++; $display("FAIL lw_14 value: got %h want 00000005", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1, nw, resp_q[$];
    logic        ee;
    int          el, ew, r0;
    logic [5:1]  ready_seen;
    model(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, e0, ee, el, ew, nw);
    model(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, e1, ee, el, ew, nw);
    @(negedge clk);
    r0 = resp_count;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h00; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_addr = 32'h04;
    ready_seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 5) ready_seen[k] = bus.req_ready;
      if (bus.resp_valid) resp_q.push_back(bus.resp_rdata);
      if (k == 4) bus.req_valid = 1'b0;
    end
    checks++;
    if (ready_seen !== 5'b00100) begin
      errors++; $display("FAIL b2b ready: got %b want 00100 (k5..k1)", ready_seen);
    end
    checks++;
    if (resp_q.size() != 2 || resp_count - r0 != 2) begin
      errors++; $display("FAIL b2b count: got %0d pulses want 2", resp_count - r0);
    end else begin
      checks++;
      if (resp_q[0] !== e0 || resp_q[1] !== e1) begin
        errors++; $display("FAIL b2b data: got %h %h want %h %h", resp_q[0], resp_q[1], e0, e1);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    int r;
    logic [1:0] sz;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 4 * MEM_WORDS + 7)), $urandom, "rand", got);
    end
  endtask

  task automatic test_mem_contents();
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_contents: %0d words differ, want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    test_mem_contents();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
